// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings and tracker types for the hazard scheduler
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  // EX operand source select
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXM = 2'd1;
  localparam logic [1:0] FWD_MWB = 2'd2;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MD_WAIT  = 2'd2,
    HZ_MEM_HOLD = 2'd3
  } hz_state_e;

  // One in-flight register writer: does it write, where, and is it a load
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             load;
  } trk_t;

  localparam trk_t TRK_NONE = '0;

  // A source depends on a writer only if it is really read and is not $0
  function automatic logic src_hit(input logic use_src, input trk_t trk,
                                   input logic [REG_W-1:0] src);
    return use_src && trk.valid && (trk.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_counter.sv
// rtl/pipeline_hazard_ctrl_md_busy_counter.sv - mul/div occupancy counter with pending destination
module md_busy_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  logic             is_div_i,
  input  logic             freeze_i,
  input  logic             dst_valid_i,
  input  logic [REG_W-1:0] dst_i,
  output logic             busy_o,
  output logic             last_o,
  output logic             dst_valid_o,
  output logic [REG_W-1:0] dst_o
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] dst_q, dst_d;
  logic             dst_v_q, dst_v_d;

  // Load on issue, otherwise count down on every unfrozen cycle
  always_comb begin
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    dst_v_d = dst_v_q;
    if (issue_i) begin
      cnt_d   = is_div_i ? DIV_CNT : MUL_CNT;
      dst_d   = dst_i;
      dst_v_d = dst_valid_i;
    end else if (!freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_CNT;
    end
  end

  // Counter and pending-destination registers
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dst_q   <= '0;
      dst_v_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      dst_v_q <= dst_v_d;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign last_o      = (cnt_q == ONE_CNT);
  assign dst_valid_o = dst_v_q;
  assign dst_o       = dst_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID-stage hazard scheduler: forwarding, stalls, flushes, freeze
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [REG_W-1:0] id_reg_dst,
  input  logic             id_mem_to_reg,
  input  logic             id_is_mul,
  input  logic             id_is_div,
  input  logic             ex_br_taken,
  input  logic             mem_wait,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             is_stalling,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy
);

  trk_t             ex_trk_q, ex_trk_d, mem_trk_q, mem_trk_d, md_trk;
  hz_state_e        state_q, ret_q;
  logic             md_busy_w, md_last_w, md_dst_v_w;
  logic [REG_W-1:0] md_dst_w;
  logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic             lu_hit, md_is_op, md_rd_hit, md_stall, md_issue;
  logic             unused_mem_load;

  // The load flag only matters while the writer is in EX
  assign unused_mem_load = mem_trk_q.load;

  // Memory back-pressure freezes the whole pipe, even during reset
  assign is_stalling = mem_wait;

  // Hazard detection, stall/flush priority and forwarding selects
  always_comb begin
    md_trk    = '{valid: md_dst_v_w, dst: md_dst_w, load: 1'b0};
    ex_hit_a  = src_hit(id_uses_rs, ex_trk_q, id_rs);
    ex_hit_b  = src_hit(id_uses_rt, ex_trk_q, id_rt);
    mem_hit_a = src_hit(id_uses_rs, mem_trk_q, id_rs);
    mem_hit_b = src_hit(id_uses_rt, mem_trk_q, id_rt);
    lu_hit    = ex_trk_q.load && (ex_hit_a || ex_hit_b);
    md_is_op  = id_valid && (id_is_mul || id_is_div);
    md_rd_hit = src_hit(id_uses_rs, md_trk, id_rs) || src_hit(id_uses_rt, md_trk, id_rt);
    md_stall  = md_busy_w && (md_is_op || md_rd_hit);
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (!rst_n) begin
      stall_if = 1'b0;
    end else if (mem_wait) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_br_taken) begin
      // the instruction in ID is wrong-path, so any stall it would cause is moot
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (lu_hit || md_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
    fwd_a   = !rst_n ? FWD_RF : ex_hit_a ? FWD_EXM : mem_hit_a ? FWD_MWB : FWD_RF;
    fwd_b   = !rst_n ? FWD_RF : ex_hit_b ? FWD_EXM : mem_hit_b ? FWD_MWB : FWD_RF;
    md_busy = rst_n && md_busy_w;
  end

  assign md_issue = rst_n && md_is_op && !stall_id && !flush_id;

  // Tracker shift: ID writer enters EX unless bubbled, EX moves to MEM
  always_comb begin
    ex_trk_d  = ex_trk_q;
    mem_trk_d = mem_trk_q;
    if (!mem_wait) begin
      mem_trk_d = ex_trk_q;
      ex_trk_d  = bubble_ex ? TRK_NONE
                : '{valid: id_valid && id_reg_write, dst: id_reg_dst, load: id_mem_to_reg};
    end
  end

  // Tracker registers
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ex_trk_q  <= TRK_NONE;
      mem_trk_q <= TRK_NONE;
    end else begin
      ex_trk_q  <= ex_trk_d;
      mem_trk_q <= mem_trk_d;
    end
  end

  md_busy_counter #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md_cnt (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .issue_i    (md_issue),
    .is_div_i   (id_is_div),
    .freeze_i   (mem_wait),
    .dst_valid_i(id_reg_write),
    .dst_i      (id_reg_dst),
    .busy_o     (md_busy_w),
    .last_o     (md_last_w),
    .dst_valid_o(md_dst_v_w),
    .dst_o      (md_dst_w)
  );

  // Scheduler state; MEM_HOLD remembers where to resume once memory is ready
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      ret_q   <= HZ_RUN;
    end else if (state_q == HZ_MEM_HOLD) begin
      if (!mem_wait) state_q <= ret_q;
    end else if (mem_wait) begin
      ret_q   <= (state_q == HZ_MD_WAIT) ? HZ_MD_WAIT : HZ_RUN;
      state_q <= HZ_MEM_HOLD;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (ex_br_taken)   state_q <= HZ_RUN;
          else if (lu_hit)   state_q <= HZ_LU_STALL;
          else if (md_issue) state_q <= HZ_MD_WAIT;
        end
        HZ_LU_STALL: state_q <= HZ_RUN;
        HZ_MD_WAIT:  if (md_last_w) state_q <= HZ_RUN;
        default:     state_q <= HZ_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_to_reg;
  logic       id_is_mul, id_is_div, ex_br_taken, mem_wait;
  logic [4:0] id_rs, id_rt, id_reg_dst;
  logic       stall_if, stall_id, bubble_ex, flush_id, is_stalling, md_busy;
  logic [1:0] fwd_a, fwd_b;

  always #5 sys_clk = ~sys_clk;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_reg_dst(id_reg_dst), .id_mem_to_reg(id_mem_to_reg), .id_is_mul(id_is_mul),
    .id_is_div(id_is_div), .ex_br_taken(ex_br_taken), .mem_wait(mem_wait),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .is_stalling(is_stalling), .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the two older register writers, and the mul/div unit's remaining time
  typedef struct { bit v; int dst; bit ld; } wr_t;
  wr_t in_ex, in_mem;
  int  md_left  = 0;
  int  md_dst   = 0;
  bit  md_dst_v = 0;

  bit  e_sif, e_sid, e_bub, e_fl, e_md;
  int  e_fa, e_fb;
  int  s_sif, s_sid, s_bub, s_fl, s_ist, s_md, s_fa, s_fb;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Which older instruction supplies a source: 0 none, 1 the one just ahead, 2 the one before it
  function automatic int supplier(bit rd, int src);
    if (!rd || src == 0) return 0;
    if (in_ex.v && in_ex.dst == src) return 1;
    if (in_mem.v && in_mem.dst == src) return 2;
    return 0;
  endfunction

  task automatic predict();
    bit lu, md_rd, md_st;
    e_fa  = supplier(id_uses_rs, int'(id_rs));
    e_fb  = supplier(id_uses_rt, int'(id_rt));
    lu    = in_ex.ld && (e_fa == 1 || e_fb == 1);
    md_rd = md_dst_v && md_dst != 0 &&
            ((id_uses_rs && int'(id_rs) == md_dst) || (id_uses_rt && int'(id_rt) == md_dst));
    md_st = (md_left > 0) && ((id_valid && (id_is_mul || id_is_div)) || md_rd);
    e_sif = 0; e_sid = 0; e_bub = 0; e_fl = 0;
    e_md  = rst_n && (md_left > 0);
    if (!rst_n) begin
      e_fa = 0; e_fb = 0;
    end else if (mem_wait) begin
      e_sif = 1; e_sid = 1;
    end else if (ex_br_taken) begin
      e_fl = 1; e_bub = 1;
    end else if (lu || md_st) begin
      e_sif = 1; e_sid = 1; e_bub = 1;
    end
  endtask

  task automatic advance();
    bit issue;
    if (!rst_n) begin
      in_ex = '{v: 0, dst: 0, ld: 0}; in_mem = in_ex;
      md_left = 0; md_dst = 0; md_dst_v = 0;
      return;
    end
    if (mem_wait) return;
    issue  = id_valid && (id_is_mul || id_is_div) && !e_sid && !e_fl;
    in_mem = in_ex;
    if (e_bub) in_ex = '{v: 0, dst: 0, ld: 0};
    else in_ex = '{v: id_valid && id_reg_write, dst: int'(id_reg_dst), ld: id_mem_to_reg};
    if (issue) begin
      md_left  = id_is_div ? DIV_LAT : MUL_LAT;
      md_dst   = int'(id_reg_dst);
      md_dst_v = id_reg_write;
    end else if (md_left > 0) begin
      md_left--;
    end
  endtask

  task automatic step(input string tag);
    predict();
    @(negedge sys_clk);
    s_sif = int'(stall_if); s_sid = int'(stall_id); s_bub = int'(bubble_ex);
    s_fl  = int'(flush_id); s_ist = int'(is_stalling); s_md = int'(md_busy);
    s_fa  = int'(fwd_a);    s_fb  = int'(fwd_b);
    chk({tag, ".stall_if"},    s_sif, int'(e_sif));
    chk({tag, ".stall_id"},    s_sid, int'(e_sid));
    chk({tag, ".bubble_ex"},   s_bub, int'(e_bub));
    chk({tag, ".flush_id"},    s_fl,  int'(e_fl));
    chk({tag, ".is_stalling"}, s_ist, int'(mem_wait));
    chk({tag, ".md_busy"},     s_md,  int'(e_md));
    chk({tag, ".fwd_a"},       s_fa,  e_fa);
    chk({tag, ".fwd_b"},       s_fb,  e_fb);
    @(posedge sys_clk);
    advance();
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit rw, input int dst, input bit ld, input bit mul, input bit dv);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_reg_dst = 5'(dst); id_mem_to_reg = ld; id_is_mul = mul; id_is_div = dv;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_br_taken = 0;
    mem_wait    = 0;
  endtask

  initial begin
    int busy_n, n_cyc;
    in_ex = '{v: 0, dst: 0, ld: 0}; in_mem = in_ex;
    rst_n = 0;
    idle();
    #1;
    step("rst0");
    mem_wait = 1;
    step("rst1");
    chk("reset.is_stalling", s_ist, 1);
    chk("reset.stall_if", s_sif, 0);
    chk("reset.md_busy", s_md, 0);
    mem_wait = 0;
    rst_n = 1;

    // forwarding from EX then from MEM
    set_id(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("t1a");
    set_id(1, 3, 0, 1, 0, 1, 4, 0, 0, 0); step("t1b");
    chk("t1.fwd_a_exm", s_fa, 1);
    chk("t1.no_stall", s_sid, 0);
    set_id(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step("t1c");
    chk("t1.fwd_a_mwb", s_fa, 2);

    // load-use: one stall cycle then forward from MEM/WB
    set_id(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step("t2a");
    set_id(1, 0, 5, 0, 1, 1, 6, 0, 0, 0); step("t2b");
    chk("t2.lu_stall", s_sid, 1);
    chk("t2.lu_bubble", s_bub, 1);
    step("t2c");
    chk("t2.after_stall", s_sid, 0);
    chk("t2.fwd_b_mwb", s_fb, 2);

    // div then a read of its destination
    idle(); step("t3d0"); step("t3d1");
    set_id(1, 0, 0, 0, 0, 1, 7, 0, 0, 1); step("t3.issue");
    set_id(1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
    busy_n = 0; n_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      step("t3");
      n_cyc++;
      if (s_md == 1) busy_n++;
      if (s_sid == 0) break;
    end
    chk("t3.busy_cycles", busy_n, DIV_LAT);
    chk("t3.resume_cycle", n_cyc, DIV_LAT + 1);

    // memory freeze during a div wait delays completion by exactly its length
    idle(); step("t5d0"); step("t5d1");
    set_id(1, 0, 0, 0, 0, 1, 7, 0, 0, 1); step("t5.issue");
    set_id(1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
    busy_n = 0; n_cyc = 0;
    for (int i = 0; i < 80; i++) begin
      mem_wait = (i >= 4 && i < 8);
      step("t5");
      n_cyc++;
      if (s_md == 1) busy_n++;
      if (s_sid == 0) break;
    end
    mem_wait = 0;
    chk("t5.busy_cycles", busy_n, DIV_LAT + 4);
    chk("t5.resume_cycle", n_cyc, DIV_LAT + 5);

    // taken branch over a load-use hit
    idle(); step("t4d0"); step("t4d1");
    set_id(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); step("t4a");
    set_id(1, 0, 5, 0, 1, 1, 6, 0, 0, 0); ex_br_taken = 1; step("t4b");
    chk("t4.flush", s_fl, 1);
    chk("t4.bubble", s_bub, 1);
    chk("t4.no_stall_if", s_sif, 0);
    ex_br_taken = 0; step("t4c");
    chk("t4.no_stall_next", s_sid, 0);

    // $0 never forwards or stalls, even from a load
    set_id(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); step("t6a");
    set_id(1, 0, 0, 1, 1, 1, 9, 0, 0, 0); step("t6b");
    chk("t6.fwd_a_zero", s_fa, 0);
    chk("t6.fwd_b_zero", s_fb, 0);
    chk("t6.no_stall", s_sid, 0);

    // reset in the middle of a div
    idle(); step("t7d0");
    set_id(1, 0, 0, 0, 0, 1, 7, 0, 0, 1); step("t7.issue");
    idle(); step("t7b"); step("t7c");
    chk("t7.busy_before_rst", s_md, 1);
    rst_n = 0; step("t7.rst");
    rst_n = 1; step("t7.after");
    chk("t7.md_busy_cleared", s_md, 0);

    // randomized traffic over a small register set
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_wait    = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
